// File: rtl/pc_pkg.sv
// Shared constants and types for the fetch-stage program-counter generator.
package pc_pkg;
    localparam int          PC_W      = 32;
    localparam logic [31:0] RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_4180;
    localparam int          STEP      = 4;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic {
        PEND_EMPTY = 1'b0,
        PEND_FULL  = 1'b1
    } pend_state_e;
endpackage

// File: rtl/pc_gen_if.sv
// Request/response bundle between the hazard/exception units and pc_gen.
interface pc_gen_if
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_W
);
    logic             stall_i;
    logic             br_en_i;
    logic [WIDTH-1:0] br_target_i;
    logic             exc_en_i;
    logic             eret_en_i;
    logic [WIDTH-1:0] epc_i;
    logic [WIDTH-1:0] pc_o;
    logic [WIDTH-1:0] pc_plus_o;
    logic             pend_o;
    logic             misalign_o;

    modport master (
        output stall_i, br_en_i, br_target_i, exc_en_i, eret_en_i, epc_i,
        input  pc_o, pc_plus_o, pend_o, misalign_o
    );

    modport slave (
        input  stall_i, br_en_i, br_target_i, exc_en_i, eret_en_i, epc_i,
        output pc_o, pc_plus_o, pend_o, misalign_o
    );
endinterface

// File: rtl/pc_redirect_buf.sv
// Single-entry buffer holding a redirect target that arrived while fetch was stalled.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] target_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] target_o
);
    pend_state_e      state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PEND_EMPTY;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // A newer capture simply overwrites the stored target.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        if (clear_i) begin
            state_d = PEND_EMPTY;
        end else if (capture_i) begin
            state_d  = PEND_FULL;
            target_d = target_i;
        end
    end

    assign valid_o  = (state_q == PEND_FULL);
    assign target_o = target_q;
endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with stall-tolerant redirect buffering.
// Optional misalignment flag enabled by defining PC_ALIGN_CHECK_EN.
module pc_gen
    import pc_pkg::*;
#(
    parameter int               WIDTH     = PC_W,
    parameter logic [WIDTH-1:0] RESET_VEC = pc_pkg::RESET_VEC[WIDTH-1:0],
    parameter logic [WIDTH-1:0] EXC_VEC   = pc_pkg::EXC_VEC[WIDTH-1:0],
    parameter int               STEP      = pc_pkg::STEP
) (
    input  logic      clk,
    input  logic      reset,
    pc_gen_if.slave   bus
);
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] pend_tgt;
    logic             pend_vld;
    logic             buf_capture, buf_clear;

    assign pc_plus = pc_q + WIDTH'(STEP);

    // exc/eret flush the buffer even mid-stall; any unstalled cycle consumes or drops it.
    assign buf_capture = bus.stall_i & bus.br_en_i & ~bus.exc_en_i & ~bus.eret_en_i;
    assign buf_clear   = bus.exc_en_i | bus.eret_en_i | ~bus.stall_i;

    pc_redirect_buf #(.WIDTH(WIDTH)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .capture_i (buf_capture),
        .clear_i   (buf_clear),
        .target_i  (bus.br_target_i),
        .valid_o   (pend_vld),
        .target_o  (pend_tgt)
    );

    always_comb begin
        pc_d = pc_plus;
        if (bus.exc_en_i)       pc_d = EXC_VEC;
        else if (bus.eret_en_i) pc_d = bus.epc_i;
        else if (bus.stall_i)   pc_d = pc_q;
        else if (bus.br_en_i)   pc_d = bus.br_target_i;
        else if (pend_vld)      pc_d = pend_tgt;
    end

    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_VEC;
        else       pc_q <= pc_d;
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign misalign_d = (pc_d % WIDTH'(STEP)) != '0;

    always_ff @(posedge clk) begin
        if (reset) misalign_q <= 1'b0;
        else       misalign_q <= misalign_d;
    end

    assign bus.misalign_o = misalign_q;
`else
    assign bus.misalign_o = 1'b0;
`endif

    assign bus.pc_o      = pc_q;
    assign bus.pc_plus_o = pc_plus;
    assign bus.pend_o    = pend_vld;
endmodule

// File: tb/tb_pc_gen.sv
// Directed + randomized bench for pc_gen against a behavioural next-PC model.
module tb_pc_gen;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pc_gen_if #(.WIDTH(32)) bus ();
    pc_gen_if #(.WIDTH(8))  bus8 ();

    pc_gen dut (.clk(clk), .reset(reset), .bus(bus));

    pc_gen #(.WIDTH(8), .RESET_VEC(8'hF8), .EXC_VEC(8'h80), .STEP(4)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8)
    );

    // Reference state: architectural PC, pending-redirect slot, alignment flag.
    logic [31:0] m_pc, m_tgt;
    logic        m_pend, m_mis;

    task automatic model_step();
        logic [31:0] npc;
        if (reset) begin
            m_pc = 32'h3000; m_pend = 1'b0; m_tgt = '0; m_mis = 1'b0;
            return;
        end
        if (bus.exc_en_i) begin
            npc = 32'h4180; m_pend = 1'b0;
        end else if (bus.eret_en_i) begin
            npc = bus.epc_i; m_pend = 1'b0;
        end else if (bus.stall_i) begin
            npc = m_pc;
            if (bus.br_en_i) begin m_pend = 1'b1; m_tgt = bus.br_target_i; end
        end else if (bus.br_en_i) begin
            npc = bus.br_target_i; m_pend = 1'b0;
        end else if (m_pend) begin
            npc = m_tgt; m_pend = 1'b0;
        end else begin
            npc = m_pc + 32'd4;
        end
`ifdef PC_ALIGN_CHECK_EN
        m_mis = (npc % 4) != 0;
`else
        m_mis = 1'b0;
`endif
        m_pc = npc;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"},   bus.pc_o,                 m_pc);
        chk({tag, ".plus"}, bus.pc_plus_o,            m_pc + 32'd4);
        chk({tag, ".pend"}, {31'd0, bus.pend_o},      {31'd0, m_pend});
        chk({tag, ".mis"},  {31'd0, bus.misalign_o},  {31'd0, m_mis});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic drive(input logic st, input logic br, input logic [31:0] tgt,
                         input logic ex, input logic er, input logic [31:0] epc);
        bus.stall_i = st; bus.br_en_i = br; bus.br_target_i = tgt;
        bus.exc_en_i = ex; bus.eret_en_i = er; bus.epc_i = epc;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        bus8.stall_i = 0; bus8.br_en_i = 0; bus8.br_target_i = 0;
        bus8.exc_en_i = 0; bus8.eret_en_i = 0; bus8.epc_i = 0;
        m_pc = '0; m_tgt = '0; m_pend = 0; m_mis = 0;

        // Reset and free-running sequence, with the 8-bit instance checking wrap.
        tick();
        chk("rst.pc", bus.pc_o, 32'h3000);
        chk("rst.pend", {31'd0, bus.pend_o}, 32'd0);
        chk("rst.mis", {31'd0, bus.misalign_o}, 32'd0);
        chk("w8.0", {24'd0, bus8.pc_o}, 32'hF8);
        chk_model("rst");
        reset = 1'b0;
        tick(); chk("seq.1", bus.pc_o, 32'h3004); chk("w8.1", {24'd0, bus8.pc_o}, 32'hFC);
        tick(); chk("seq.2", bus.pc_o, 32'h3008); chk("w8.2", {24'd0, bus8.pc_o}, 32'h00);
        tick(); chk("seq.3", bus.pc_o, 32'h300C); chk("w8.3", {24'd0, bus8.pc_o}, 32'h04);
        chk_model("seq");

        // Unstalled branch.
        drive(0, 1, 32'h3100, 0, 0, 0); tick();
        chk("br.pc", bus.pc_o, 32'h3100); chk_model("br");

        // Branch during stall is buffered, applied on release.
        drive(1, 1, 32'h3200, 0, 0, 0); tick();
        chk("stall1.pc", bus.pc_o, 32'h3100); chk("stall1.pend", {31'd0, bus.pend_o}, 32'd1);
        drive(1, 0, 0, 0, 0, 0); tick();
        chk("stall2.pc", bus.pc_o, 32'h3100); chk_model("stall2");
        drive(0, 0, 0, 0, 0, 0); tick();
        chk("rel.pc", bus.pc_o, 32'h3200); chk("rel.pend", {31'd0, bus.pend_o}, 32'd0);

        // Exception while a redirect is pending, then eret.
        drive(1, 1, 32'h3300, 0, 0, 0); tick(); chk_model("pend");
        drive(1, 0, 0, 1, 0, 0); tick();
        chk("exc.pc", bus.pc_o, 32'h4180); chk("exc.pend", {31'd0, bus.pend_o}, 32'd0);
        drive(0, 0, 0, 0, 1, 32'h3010); tick();
        chk("eret.pc", bus.pc_o, 32'h3010);
        drive(0, 0, 0, 0, 0, 0); tick();
        chk("post_eret.pc", bus.pc_o, 32'h3014);

        // exc and eret together: exception wins.
        drive(0, 0, 0, 1, 1, 32'h5000); tick();
        chk("exc_eret.pc", bus.pc_o, 32'h4180);

        // Live branch beats a buffered one on release.
        drive(1, 1, 32'h3400, 0, 0, 0); tick();
        drive(0, 1, 32'h3500, 0, 0, 0); tick();
        chk("live_wins.pc", bus.pc_o, 32'h3500); chk_model("live_wins");

        // Reset mid-stall discards the buffer.
        drive(1, 1, 32'h3600, 0, 0, 0); tick();
        reset = 1'b1; tick();
        chk("rst_stall.pend", {31'd0, bus.pend_o}, 32'd0);
        reset = 1'b0; drive(0, 0, 0, 0, 0, 0); tick();
        chk("rst_stall.pc", bus.pc_o, 32'h3004);

        // 32-bit wrap.
        drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        chk("wrap.pc", bus.pc_o, 32'h0000_0000); chk_model("wrap");

        // Misaligned redirect, follow-on, realign.
        drive(0, 1, 32'h3102, 0, 0, 0); tick();
        chk("mis1.pc", bus.pc_o, 32'h3102); chk_model("mis1");
        drive(0, 0, 0, 0, 0, 0); tick();
        chk("mis2.pc", bus.pc_o, 32'h3106); chk_model("mis2");
        drive(0, 1, 32'h3200, 0, 0, 0); tick();
        chk("mis3.pc", bus.pc_o, 32'h3200); chk_model("mis3");
`ifdef PC_ALIGN_CHECK_EN
        chk("mis3.flag", {31'd0, bus.misalign_o}, 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  {$urandom} & 32'hFFFF_FFFE, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, {$urandom} & 32'hFFFF_FFFC);
            if ($urandom_range(0, 7) == 0) bus.br_target_i = $urandom;
            tick();
            chk_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
